hdmi_tx_config_sequencer: RTL and testbench

Power-up and hot-plug configuration controller for the ADV7513 HDMI transmitter. It walks a fixed register table and issues one I2C byte write per entry through a handshake to an external I2C write master. It handles NACK retries and watchdog timeouts. It re-runs the full sequence on transmitter interrupt or on software request. It sits beside hdmi_generator in the top level and replaces the free-running I2C config block.

---
 rtl/hdmi_tx_cfg_pkg.sv | 45 ++++
 rtl/sync_fall_detect.sv | 33 +++
 rtl/hdmi_tx_config_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hdmi_tx_config_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tx_cfg_pkg.sv
// rtl/hdmi_tx_cfg_pkg.sv - FSM states and the ADV7513 register table for the config sequencer
package hdmi_tx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PWR = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } cfg_state_e;

  localparam int NUM_REGS = 14;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Power-up first, interrupt clear last so a stale HPD/interrupt cannot survive the rerun.
  function automatic cfg_entry_t cfg_entry(input logic [IDX_W-1:0] idx);
    cfg_entry_t e;
    e = '0;
    case (int'(idx))
      0:       e = '{reg_addr: 8'h41, data: 8'h10};
      1:       e = '{reg_addr: 8'h98, data: 8'h03};
      2:       e = '{reg_addr: 8'h9A, data: 8'hE0};
      3:       e = '{reg_addr: 8'h9C, data: 8'h30};
      4:       e = '{reg_addr: 8'h9D, data: 8'h61};
      5:       e = '{reg_addr: 8'hA2, data: 8'hA4};
      6:       e = '{reg_addr: 8'hA3, data: 8'hA4};
      7:       e = '{reg_addr: 8'hE0, data: 8'hD0};
      8:       e = '{reg_addr: 8'hF9, data: 8'h00};
      9:       e = '{reg_addr: 8'h15, data: 8'h00};
      10:      e = '{reg_addr: 8'h16, data: 8'h30};
      11:      e = '{reg_addr: 8'h17, data: 8'h02};
      12:      e = '{reg_addr: 8'hAF, data: 8'h06};
      13:      e = '{reg_addr: 8'h96, data: 8'hF6};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// rtl/sync_fall_detect.sv - two-flop synchronizer with a one-cycle falling-edge pulse
module sync_fall_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_fall
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to 0 so a line already low at reset release yields no event.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/hdmi_tx_config_sequencer.sv
// rtl/hdmi_tx_config_sequencer.sv - ADV7513 register-table walker with retry, watchdog and rerun handling
module hdmi_tx_config_sequencer
  import hdmi_tx_cfg_pkg::*;
#(
  parameter int         POWERUP_DELAY_CYCLES = 10_000_000,
  parameter int         TIMEOUT_CYCLES       = 65_536,
  parameter int         MAX_RETRIES          = 3,
  parameter logic [6:0] DEV_ADDR             = 7'h39
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_hdmi_tx_int,
  output logic             o_i2c_req,
  output logic [6:0]       o_i2c_dev_addr,
  output logic [7:0]       o_i2c_reg_addr,
  output logic [7:0]       o_i2c_data,
  input  logic             i_i2c_done,
  input  logic             i_i2c_nack,
  output logic             o_busy,
  output logic             o_config_done,
  output logic             o_config_error,
  output logic [IDX_W-1:0] o_index
);
  localparam int DLY_W = $clog2(POWERUP_DELAY_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(POWERUP_DELAY_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(POWERUP_DELAY_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  cfg_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             pending_q, pending_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       data_q, data_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic       int_evt;
  logic       restart_evt;
  logic       ack_ok;
  logic       write_fail;
  logic       state_busy;
  cfg_entry_t entry;

  sync_fall_detect u_int_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_hdmi_tx_int),
    .o_fall    (int_evt)
  );

  assign restart_evt = i_start | int_evt;
  assign ack_ok      = i_i2c_done & ~i_i2c_nack;
  assign write_fail  = (i_i2c_done & i_i2c_nack) | (wd_q == WD_MAX);
  assign state_busy  = state_q inside {ST_WAIT_PWR, ST_ISSUE, ST_WAIT_ACK};
  assign entry       = cfg_entry(idx_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      dly_q      <= '0;
      wd_q       <= '0;
      idx_q      <= '0;
      rty_q      <= '0;
      pending_q  <= 1'b0;
      reg_addr_q <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      wd_q       <= wd_d;
      idx_q      <= idx_d;
      rty_q      <= rty_d;
      pending_q  <= pending_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    wd_d       = wd_q;
    idx_d      = idx_q;
    rty_d      = rty_q;
    pending_d  = pending_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: state_d = ST_WAIT_PWR;
      ST_WAIT_PWR: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_ISSUE;
        end else if (dly_q != DLY_MAX) begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        reg_addr_d = entry.reg_addr;
        data_d     = entry.data;
        wd_d       = '0;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        // A clean ack wins over a watchdog expiring in the same cycle.
        if (ack_ok) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            rty_d   = '0;
            state_d = ST_ISSUE;
          end
        end else if (write_fail) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (restart_evt || pending_q) begin
          state_d = ST_WAIT_PWR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any number of restarts while busy collapse into a single rerun.
    if (state_busy && restart_evt) begin
      pending_d = 1'b1;
    end
    if (state_d == ST_WAIT_PWR && state_q != ST_WAIT_PWR) begin
      dly_d     = '0;
      idx_d     = '0;
      rty_d     = '0;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    req_d   = (state_d == ST_WAIT_ACK);
    busy_d  = state_d inside {ST_WAIT_PWR, ST_ISSUE, ST_WAIT_ACK};
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  assign o_i2c_req      = req_q;
  assign o_i2c_dev_addr = DEV_ADDR;
  assign o_i2c_reg_addr = reg_addr_q;
  assign o_i2c_data     = data_q;
  assign o_busy         = busy_q;
  assign o_config_done  = done_q;
  assign o_config_error = error_q;
  assign o_index        = idx_q;

endmodule

// File: tb/tb_hdmi_tx_config_sequencer.sv
// tb/tb_hdmi_tx_config_sequencer.sv - self-checking bench with an I2C responder model and write scoreboard
module tb_hdmi_tx_config_sequencer;
  localparam int PWR  = 16;
  localparam int TMO  = 32;
  localparam int MR   = 3;
  localparam int NREG = 14;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       int_n    = 1'b1;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic       req;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] data;
  logic       busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] idx;

  hdmi_tx_config_sequencer #(
    .POWERUP_DELAY_CYCLES (PWR),
    .TIMEOUT_CYCLES       (TMO),
    .MAX_RETRIES          (MR),
    .DEV_ADDR             (7'h39)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_start        (start),
    .i_hdmi_tx_int  (int_n),
    .o_i2c_req      (req),
    .o_i2c_dev_addr (dev_addr),
    .o_i2c_reg_addr (reg_addr),
    .o_i2c_data     (data),
    .i_i2c_done     (i2c_done),
    .i_i2c_nack     (i2c_nack),
    .o_busy         (busy),
    .o_config_done  (cfg_done),
    .o_config_error (cfg_err),
    .o_index        (idx)
  );

  always #5 clk = ~clk;

  logic [15:0] tab [NREG] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
                              16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'hAF06, 16'h96F6};

  typedef struct {
    int ni;
    int nc;
    int hi;
    int writes;
    int done;
    int err;
    int index;
  } vec_t;
  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;
  int m_nack_ra = -1;
  int m_nack_left = 0;
  int m_hang_ra = -1;
  int ack_wait = 0;
  int log_idx[$];
  int log_ra[$];
  int log_da[$];
  int exp_q[$];

  // I2C master model: done 3 cycles after req, nack/hang chosen by register address.
  initial begin
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (req === 1'b1) begin
        ack_wait++;
        if (ack_wait == 1) begin
          log_idx.push_back(int'(idx));
          log_ra.push_back(int'(reg_addr));
          log_da.push_back(int'(data));
        end
        if (ack_wait == 3 && int'(reg_addr) != m_hang_ra) begin
          i2c_done = 1'b1;
          if (int'(reg_addr) == m_nack_ra && m_nack_left > 0) begin
            i2c_nack = 1'b1;
            m_nack_left--;
          end
          ack_wait = 0;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (busy === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_ra.delete();
    log_da.delete();
    exp_q.delete();
  endtask

  // Reference: each entry is issued min(failures, MR)+1 times; more than MR failures ends the run.
  task automatic build_expect(input int ni, input int nc, input int hi, output bit err, output int last);
    int fails;
    err = 1'b0;
    last = NREG - 1;
    for (int i = 0; i < NREG; i++) begin
      fails = (i == hi) ? 1000 : ((i == ni) ? nc : 0);
      for (int a = 0; a <= fails && a <= MR; a++) exp_q.push_back(i);
      if (fails > MR) begin
        err = 1'b1;
        last = i;
        break;
      end
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, log_idx.size(), exp_q.size());
    n = (log_idx.size() < exp_q.size()) ? log_idx.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d_index", tag, i), log_idx[i], exp_q[i]);
      check($sformatf("%s_w%0d_reg", tag, i), log_ra[i], int'(tab[exp_q[i]][15:8]));
      check($sformatf("%s_w%0d_data", tag, i), log_da[i], int'(tab[exp_q[i]][7:0]));
    end
  endtask

  task automatic set_model(input int ni, input int nc, input int hi);
    m_nack_ra   = (ni >= 0) ? int'(tab[ni][15:8]) : -1;
    m_nack_left = nc;
    m_hang_ra   = (hi >= 0) ? int'(tab[hi][15:8]) : -1;
  endtask

  task automatic run_seq(input string tag, input int ni, input int nc, input int hi,
                         output bit exp_err, output int exp_last);
    bit ok;
    set_model(ni, nc, hi);
    clear_log();
    build_expect(ni, nc, hi, exp_err, exp_last);
    pulse_start();
    wait_idle(3000, ok);
    check({tag, "_idle"}, int'(ok), 1);
    compare_log(tag);
    check({tag, "_done"}, int'(cfg_done), exp_err ? 0 : 1);
    check({tag, "_error"}, int'(cfg_err), exp_err ? 1 : 0);
    check({tag, "_index"}, int'(idx), exp_last);
    check({tag, "_req"}, int'(req), 0);
  endtask

  initial begin
    bit   ok;
    bit   e;
    int   last;
    int   lat;
    int   cnt;
    int   ni;
    int   nc;
    int   hi;
    vec_t v;

    vecs[0] = '{-1, 0, -1, 14, 1, 0, 13};
    vecs[1] = '{ 5, 2, -1, 16, 1, 0, 13};
    vecs[2] = '{ 5, 4, -1,  9, 0, 1,  5};
    vecs[3] = '{-1, 0, -1, 14, 1, 0, 13};
    vecs[4] = '{-1, 0,  2,  6, 0, 1,  2};
    vecs[5] = '{ 0, 3, -1, 17, 1, 0, 13};
    vecs[6] = '{13, 4, -1, 17, 0, 1, 13};

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", int'(req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(cfg_done), 0);
    check("rst_error", int'(cfg_err), 0);
    check("rst_index", int'(idx), 0);
    check("rst_reg", int'(reg_addr), 0);
    check("rst_data", int'(data), 0);
    check("dev_addr", int'(dev_addr), 'h39);

    // Power-up sequence: first request 18 cycles after reset release.
    set_model(-1, 0, -1);
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      lat++;
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("first_req_latency", ok ? lat : -1, PWR + 2);
    check("first_reg", int'(reg_addr), 'h41);
    check("first_data", int'(data), 'h10);
    wait_idle(3000, ok);
    check("pwrup_idle", int'(ok), 1);
    build_expect(-1, 0, -1, e, last);
    compare_log("pwrup");
    check("pwrup_done", int'(cfg_done), 1);
    check("pwrup_busy", int'(busy), 0);
    check("pwrup_error", int'(cfg_err), 0);

    // Interrupt held low 10 cycles: done clears quickly, exactly one sequence.
    clear_log();
    @(negedge clk);
    int_n = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (lat < 0 && cfg_done === 1'b0) lat = c;
    end
    int_n = 1'b1;
    check("int_done_clear_fast", int'(lat > 0 && lat <= 4), 1);
    wait_idle(3000, ok);
    check("int_idle", int'(ok), 1);
    repeat (60) tick();
    build_expect(-1, 0, -1, e, last);
    compare_log("int_once");
    check("int_once_done", int'(cfg_done), 1);

    // Two extra interrupts while busy give exactly one rerun.
    clear_log();
    @(negedge clk);
    int_n = 1'b0;
    repeat (3) @(negedge clk);
    int_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      int_n = 1'b0;
      repeat (3) @(negedge clk);
      int_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    wait_idle(3000, ok);
    check("int_pend_idle", int'(ok), 1);
    build_expect(-1, 0, -1, e, last);
    build_expect(-1, 0, -1, e, last);
    compare_log("int_pend");
    check("int_pend_done", int'(cfg_done), 1);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_seq($sformatf("vec%0d", i), v.ni, v.nc, v.hi, e, last);
      check($sformatf("vec%0d_writes", i), log_idx.size(), v.writes);
      check($sformatf("vec%0d_tdone", i), int'(cfg_done), v.done);
      check($sformatf("vec%0d_terror", i), int'(cfg_err), v.err);
      check($sformatf("vec%0d_tindex", i), int'(idx), v.index);
    end

    // Watchdog: request held TMO+1 cycles before each retry.
    set_model(-1, 0, 2);
    clear_log();
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (req === 1'b1 && idx == 4'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("hang_rise_seen", int'(ok), 1);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      cnt++;
      if (req !== 1'b1) break;
    end
    check("hang_req_width", cnt, TMO + 1);
    wait_idle(3000, ok);
    check("hang_idle", int'(ok), 1);
    build_expect(-1, 0, 2, e, last);
    compare_log("hang");
    check("hang_error", int'(cfg_err), 1);
    check("hang_index", int'(idx), 2);

    for (int r = 0; r < 6; r++) begin
      ni = int'($urandom_range(0, NREG - 1));
      nc = int'($urandom_range(0, 5));
      hi = -1;
      if ($urandom_range(0, 3) == 0) begin
        hi = ni;
        ni = -1;
      end
      run_seq($sformatf("rnd%0d", r), ni, nc, hi, e, last);
    end

    // Async reset during a write drops req at once; sequence restarts from index 0.
    set_model(-1, 0, -1);
    clear_log();
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (req === 1'b1 && idx == 4'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_seen", int'(ok), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", int'(req), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(cfg_done), 0);
    check("rst_mid_error", int'(cfg_err), 0);
    check("rst_mid_index", int'(idx), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    wait_idle(3000, ok);
    check("rst_mid_idle", int'(ok), 1);
    build_expect(-1, 0, -1, e, last);
    compare_log("rst_mid");
    check("rst_mid_final_done", int'(cfg_done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
